// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port round-robin arbiter and sequencer for the 256x16 block RAM
module mem_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16,
    parameter int LOCK_MAX   = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  a_req_i,
    input  logic                  b_req_i,
    input  logic                  a_we_i,
    input  logic                  b_we_i,
    input  logic                  a_lock_i,
    input  logic                  b_lock_i,
    input  logic [ADDR_WIDTH-1:0] a_addr_i,
    input  logic [ADDR_WIDTH-1:0] b_addr_i,
    input  logic [DATA_WIDTH-1:0] a_data_i,
    input  logic [DATA_WIDTH-1:0] b_data_i,
    output logic                  a_ack_o,
    output logic                  b_ack_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  grant_o,
    output logic                  busy_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_data_o,
    output logic                  mem_we_no,
    input  logic [DATA_WIDTH-1:0] mem_data_i
);

    typedef enum logic {IDLE, ACCESS} state_t;

    // 4 bits covers LOCK_MAX up to 15; the compare is done one bit wider
    localparam int CNT_W = 4;

    state_t state_q, state_d;

    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  mem_we_n_q, mem_we_n_d;
    logic                  a_ack_q, a_ack_d;
    logic                  b_ack_q, b_ack_d;
    logic                  grant_q, grant_d;
    logic                  busy_q, busy_d;
    logic                  lock_req_q, lock_req_d;
    logic                  lock_held_q, lock_held_d;
    logic [CNT_W-1:0]      lock_cnt_q, lock_cnt_d;

    logic a_elig, b_elig, win_valid, win_b, lock_extend;

    // A held lock shuts out the other port; otherwise a tie goes to the port not granted last
    assign a_elig    = a_req_i && (!lock_held_q || (grant_q == 1'b0));
    assign b_elig    = b_req_i && (!lock_held_q || (grant_q == 1'b1));
    assign win_valid = a_elig || b_elig;
    assign win_b     = b_elig && (!a_elig || (grant_q == 1'b0));

    // Lock may be extended only while the run stays below LOCK_MAX accesses
    assign lock_extend = lock_req_q &&
                         (({1'b0, lock_cnt_q} + 5'd1) < 5'(LOCK_MAX));

    // State register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: ACCESS always lasts exactly one cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (win_valid) state_d = ACCESS;
            ACCESS:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output next values: grant and launch in IDLE, complete and release in ACCESS
    always_comb begin
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
        rdata_d     = rdata_q;
        mem_we_n_d  = mem_we_n_q;
        a_ack_d     = 1'b0;
        b_ack_d     = 1'b0;
        grant_d     = grant_q;
        busy_d      = busy_q;
        lock_req_d  = lock_req_q;
        lock_held_d = lock_held_q;
        lock_cnt_d  = lock_cnt_q;
        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    mem_addr_d = win_b ? b_addr_i : a_addr_i;
                    mem_data_d = win_b ? b_data_i : a_data_i;
                    mem_we_n_d = win_b ? ~b_we_i : ~a_we_i;
                    lock_req_d = win_b ? b_lock_i : a_lock_i;
                    grant_d    = win_b;
                    busy_d     = 1'b1;
                end
            end
            ACCESS: begin
                rdata_d    = mem_data_i;
                a_ack_d    = (grant_q == 1'b0);
                b_ack_d    = (grant_q == 1'b1);
                mem_we_n_d = 1'b1;
                busy_d     = 1'b0;
                if (lock_extend) begin
                    lock_held_d = 1'b1;
                    lock_cnt_d  = lock_cnt_q + 1'b1;
                end else begin
                    lock_held_d = 1'b0;
                    lock_cnt_d  = '0;
                end
            end
            default: ;
        endcase
    end

    // Output and lock registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            rdata_q     <= '0;
            mem_we_n_q  <= 1'b1;
            a_ack_q     <= 1'b0;
            b_ack_q     <= 1'b0;
            grant_q     <= 1'b1;
            busy_q      <= 1'b0;
            lock_req_q  <= 1'b0;
            lock_held_q <= 1'b0;
            lock_cnt_q  <= '0;
        end else begin
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            rdata_q     <= rdata_d;
            mem_we_n_q  <= mem_we_n_d;
            a_ack_q     <= a_ack_d;
            b_ack_q     <= b_ack_d;
            grant_q     <= grant_d;
            busy_q      <= busy_d;
            lock_req_q  <= lock_req_d;
            lock_held_q <= lock_held_d;
            lock_cnt_q  <= lock_cnt_d;
        end
    end

    assign mem_addr_o = mem_addr_q;
    assign mem_data_o = mem_data_q;
    assign rdata_o    = rdata_q;
    assign mem_we_no  = mem_we_n_q;
    assign a_ack_o    = a_ack_q;
    assign b_ack_o    = b_ack_q;
    assign grant_o    = grant_q;
    assign busy_o     = busy_q;

endmodule
